// File: rtl/raster_pkg.sv
// Shared types and constants for the 8x8 raster engine.
package raster_pkg;

    localparam int GRID_DIM = 8;
    localparam int COORD_W  = 3;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_PIXEL = 2'b01,
        OP_LINE  = 2'b10,
        OP_RECT  = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DRAW = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Last covered coordinate of a span, clamped to the grid edge (4-bit arithmetic).
    function automatic coord_t clip_end(input coord_t start, input coord_t len);
        logic [COORD_W:0] sum;
        sum = {1'b0, start} + {1'b0, len} - 4'd1;
        return (sum > 4'(GRID_DIM - 1)) ? coord_t'(GRID_DIM - 1) : sum[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/raster_line_stepper.sv
// Integer Bresenham stepper: load endpoints, then one step per strobe until last.
module raster_line_stepper
    import raster_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   step,
    input  coord_t x1,
    input  coord_t y1,
    input  coord_t x2,
    input  coord_t y2,
    output coord_t x,
    output coord_t y,
    output logic   last
);

    // dx is |dx| (>= 0), dy is -|dy| (<= 0); err stays within +-14
    logic signed [5:0] dx, dy, err, err_n, ld_dx, ld_dy;
    logic signed [6:0] e2, dx_w, dy_w;
    logic              sx_neg, sy_neg;
    coord_t            xe, ye, x_n, y_n;

    always_comb begin
        ld_dx = (x2 >= x1) ? $signed({3'b000, x2 - x1}) : $signed({3'b000, x1 - x2});
        ld_dy = (y2 >= y1) ? -$signed({3'b000, y2 - y1}) : -$signed({3'b000, y1 - y2});
        dx_w  = {dx[5], dx};
        dy_w  = {dy[5], dy};
        e2    = {err, 1'b0};
        err_n = err;
        x_n   = x;
        y_n   = y;
        if (e2 >= dy_w) begin
            err_n = err_n + dy;
            x_n   = sx_neg ? x - 3'd1 : x + 3'd1;
        end
        if (e2 <= dx_w) begin
            err_n = err_n + dx;
            y_n   = sy_neg ? y - 3'd1 : y + 3'd1;
        end
    end

    assign last = (x == xe) && (y == ye);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x      <= '0;
            y      <= '0;
            xe     <= '0;
            ye     <= '0;
            dx     <= '0;
            dy     <= '0;
            err    <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
        end else if (load) begin
            x      <= x1;
            y      <= y1;
            xe     <= x2;
            ye     <= y2;
            dx     <= ld_dx;
            dy     <= ld_dy;
            err    <= ld_dx + ld_dy;
            sx_neg <= (x2 < x1);
            sy_neg <= (y2 < y1);
        end else if (step) begin
            x   <= x_n;
            y   <= y_n;
            err <= err_n;
        end
    end

endmodule

// File: rtl/raster_engine.sv
// 8x8 framebuffer rasteriser: CLEAR / PIXEL / LINE / RECT, one write per DRAW cycle.
// Define RASTER_XOR_EN to make PIXEL, LINE and RECT toggle pixels instead of setting them.
//   state   | meaning
//   ST_IDLE | waiting for cmd_valid; only state that accepts a command
//   ST_DRAW | executing the latched command, one row or pixel per cycle
//   ST_DONE | single-cycle completion pulse, strobes still dropped
module raster_engine
    import raster_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic [2:0] x1,
    input  logic [2:0] y1,
    input  logic [2:0] x2,
    input  logic [2:0] y2,
    input  logic [2:0] width,
    input  logic [2:0] height,
    output logic       busy,
    output logic       done,
    output logic       cmd_drop,
    input  logic [2:0] rd_row,
    output logic [7:0] rd_data
);

    state_t  state, state_n;
    opcode_t op;
    coord_t  rx, ry, rx0, rx_end, ry_end, clr_left, clr_row;
    coord_t  wr_x, wr_y, ln_x, ln_y;
    logic    rect_empty, accept, wr_en, clr_en, ln_step, ln_last;
    logic [GRID_DIM*GRID_DIM-1:0] fb;

    assign accept   = cmd_valid && (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign clr_row  = ~clr_left;   // down-counter 7..0 clears rows 0..7
    assign rd_data  = fb[{rd_row, 3'b000} +: GRID_DIM];

    raster_line_stepper u_line (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .step (ln_step),
        .x1   (x1),
        .y1   (y1),
        .x2   (x2),
        .y2   (y2),
        .x    (ln_x),
        .y    (ln_y),
        .last (ln_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        wr_en   = 1'b0;
        clr_en  = 1'b0;
        ln_step = 1'b0;
        wr_x    = ln_x;
        wr_y    = ln_y;
        case (state)
            ST_IDLE: if (accept) state_n = ST_DRAW;
            ST_DRAW: begin
                case (op)
                    OP_CLEAR: begin
                        clr_en = 1'b1;
                        if (clr_left == '0) state_n = ST_DONE;
                    end
                    OP_PIXEL: begin
                        wr_en   = 1'b1;
                        wr_x    = rx;
                        wr_y    = ry;
                        state_n = ST_DONE;
                    end
                    OP_LINE: begin
                        wr_en = 1'b1;
                        if (ln_last) state_n = ST_DONE;
                        else         ln_step = 1'b1;
                    end
                    default: begin
                        wr_x = rx;
                        wr_y = ry;
                        if (rect_empty) begin
                            state_n = ST_DONE;
                        end else begin
                            wr_en = 1'b1;
                            if ((rx == rx_end) && (ry == ry_end)) state_n = ST_DONE;
                        end
                    end
                endcase
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op         <= OP_CLEAR;
            rx         <= '0;
            ry         <= '0;
            rx0        <= '0;
            rx_end     <= '0;
            ry_end     <= '0;
            rect_empty <= 1'b0;
            clr_left   <= '0;
        end else if (accept) begin
            op         <= opcode_t'(cmd);
            rx         <= x1;
            ry         <= y1;
            rx0        <= x1;
            rx_end     <= clip_end(x1, width);
            ry_end     <= clip_end(y1, height);
            rect_empty <= (width == '0) || (height == '0);
            clr_left   <= coord_t'(GRID_DIM - 1);
        end else if (state == ST_DRAW) begin
            if (op == OP_CLEAR) clr_left <= clr_left - 3'd1;
            if ((op == OP_RECT) && !rect_empty) begin
                if (rx == rx_end) begin
                    rx <= rx0;
                    ry <= ry + 3'd1;
                end else begin
                    rx <= rx + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_drop <= 1'b0;
        end else if (cmd_valid && busy) begin
            cmd_drop <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb <= '0;
        end else if (clr_en) begin
            fb[{clr_row, 3'b000} +: GRID_DIM] <= '0;
        end else if (wr_en) begin
`ifdef RASTER_XOR_EN
            fb[{wr_y, wr_x}] <= ~fb[{wr_y, wr_x}];
`else
            fb[{wr_y, wr_x}] <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_raster_engine.sv
// Self-checking bench for raster_engine: directed cases plus random commands vs a pixel-list model.
module tb_raster_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [2:0] x1, y1, x2, y2, width, height, rd_row;
    logic       busy, done, cmd_drop;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;
    bit fbm [8][8];   // [y][x]
    bit exp_drop;

    raster_engine dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2), .width(width), .height(height),
        .busy(busy), .done(done), .cmd_drop(cmd_drop),
        .rd_row(rd_row), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic plot(input int x, input int y);
`ifdef RASTER_XOR_EN
        fbm[y][x] = ~fbm[y][x];
`else
        fbm[y][x] = 1'b1;
`endif
    endtask

    function automatic logic [7:0] model_row(input int r);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = fbm[r][i];
        return b;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Applies a command to the model and returns the expected number of DRAW cycles.
    task automatic model_cmd(input int op, input int a, input int b, input int c, input int d,
                             input int w, input int h, output int n);
        int dx, dy, sx, sy, err, e2, xa, ya, xe, ye;
        case (op)
            0: begin
                for (int r = 0; r < 8; r++) for (int i = 0; i < 8; i++) fbm[r][i] = 1'b0;
                n = 8;
            end
            1: begin
                plot(a, b);
                n = 1;
            end
            2: begin
                dx = iabs(c - a); dy = -iabs(d - b);
                sx = (a < c) ? 1 : -1; sy = (b < d) ? 1 : -1;
                err = dx + dy; xa = a; ya = b;
                while (1) begin
                    plot(xa, ya);
                    if (xa == c && ya == d) break;
                    e2 = 2 * err;
                    if (e2 >= dy) begin err += dy; xa += sx; end
                    if (e2 <= dx) begin err += dx; ya += sy; end
                end
                n = ((dx > -dy) ? dx : -dy) + 1;
            end
            default: begin
                if (w == 0 || h == 0) begin
                    n = 1;
                end else begin
                    xe = (a + w - 1 > 7) ? 7 : a + w - 1;
                    ye = (b + h - 1 > 7) ? 7 : b + h - 1;
                    for (int yy = b; yy <= ye; yy++)
                        for (int xx = a; xx <= xe; xx++) plot(xx, yy);
                    n = (xe - a + 1) * (ye - b + 1);
                end
            end
        endcase
    endtask

    task automatic start(input int op, input int a, input int b, input int c, input int d,
                         input int w, input int h);
        @(negedge clk);
        cmd = 2'(op); x1 = 3'(a); y1 = 3'(b); x2 = 3'(c); y2 = 3'(d);
        width = 3'(w); height = 3'(h);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        check("no_done_first_draw", done, 0);
    endtask

    task automatic wait_done(input string tag, input int exp_n);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, n, exp_n);
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
    endtask

    task automatic finish_cmd();
        @(posedge clk);
        #1;
        check("done_cleared", done, 0);
        check("idle_after_done", busy, 0);
        check("cmd_drop", cmd_drop, exp_drop);
    endtask

    task automatic check_fb(input string tag);
        for (int r = 0; r < 8; r++) begin
            rd_row = 3'(r);
            #1;
            check(tag, rd_data, model_row(r));
        end
    endtask

    task automatic run(input string tag, input int op, input int a, input int b, input int c,
                       input int d, input int w, input int h);
        int n;
        model_cmd(op, a, b, c, d, w, h, n);
        start(op, a, b, c, d, w, h);
        wait_done(tag, n);
        finish_cmd();
        check_fb(tag);
    endtask

    initial begin
        int n, op, r;
        rst = 1'b1; cmd_valid = 1'b0; cmd = '0;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0; width = '0; height = '0; rd_row = '0;
        exp_drop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_drop", cmd_drop, 0);
        check_fb("rst_fb");
        @(negedge clk);
        rst = 1'b0;

        // PIXEL (3,5): busy two cycles, write visible in the DONE cycle
        model_cmd(1, 3, 5, 0, 0, 0, 0, n);
        start(1, 3, 5, 0, 0, 0, 0);
        wait_done("pixel_cycles", 1);
        rd_row = 3'd5;
        #1;
        check("pixel_row5", rd_data, 8'h08);
        finish_cmd();
        check_fb("pixel_fb");

        run("pixel_again", 1, 3, 5, 0, 0, 0, 0);
        rd_row = 3'd5;
        #1;
`ifdef RASTER_XOR_EN
        check("pixel_twice_row5", rd_data, 8'h00);
`else
        check("pixel_twice_row5", rd_data, 8'h08);
`endif

        run("clear1", 0, 0, 0, 0, 0, 0, 0);
        run("line_diag", 2, 0, 0, 7, 7, 0, 0);
        for (int i = 0; i < 8; i++) begin
            rd_row = 3'(i);
            #1;
            check("diag_row", rd_data, 32'(1 << i));
        end
        run("clear2", 0, 0, 0, 0, 0, 0, 0);
        run("line_negdx", 2, 6, 1, 1, 3, 0, 0);
        run("line_point", 2, 2, 2, 2, 2, 0, 0);
        run("rect_clip", 3, 6, 6, 0, 0, 4, 3);
        rd_row = 3'd6; #1; check("rect_row6", rd_data, 8'hC0);
        rd_row = 3'd7; #1; check("rect_row7", rd_data, 8'hC0);
        run("rect_w0", 3, 1, 1, 0, 0, 0, 5);

        // Strobes during DRAW and DONE are dropped and do not touch the framebuffer
        model_cmd(2, 0, 7, 7, 7, 0, 0, n);
        start(2, 0, 7, 7, 7, 0, 0);
        @(negedge clk);
        cmd = 2'b01; x1 = 3'd0; y1 = 3'd0; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        exp_drop = 1'b1;
        check("drop_set_busy", cmd_drop, 1);
        wait_done("drop_line_cycles", n - 1);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("drop_in_done_idle", busy, 0);
        check("drop_in_done_nodone", done, 0);
        @(posedge clk);
        #1;
        check("drop_not_accepted", busy, 0);
        check("drop_sticky", cmd_drop, 1);
        check_fb("drop_fb");

        run("rect_full", 3, 0, 0, 0, 0, 7, 7);
        run("rect_edge", 3, 1, 1, 0, 0, 7, 7);
        run("clear_full", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            rd_row = 3'(i);
            #1;
            check("clear_zero", rd_data, 0);
        end

        for (int k = 0; k < 30; k++) begin
            r  = int'($urandom_range(0, 9));
            op = (r == 0) ? 0 : 1 + (r % 3);
            run("random", op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end

        // Reset in the middle of a LINE abandons it and clears everything
        start(2, 0, 0, 7, 3, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_drop", cmd_drop, 0);
        for (int yy = 0; yy < 8; yy++) for (int xx = 0; xx < 8; xx++) fbm[yy][xx] = 1'b0;
        exp_drop = 1'b0;
        check_fb("midrst_fb");
        @(negedge clk);
        rst = 1'b0;
        run("post_rst_pixel", 1, 7, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/raster_engine.md
RASTER_ENGINE -- requirements
Module: raster_engine

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port cmd_valid, input, 1 bit: single-cycle command strobe from the command processor.
REQ-004 SHALL have port cmd, input, 2 bits: opcode; 00 CLEAR, 01 PIXEL, 10 LINE, 11 RECT.
REQ-005 SHALL have ports x1, y1, x2, y2, width, height, input, 3 bits each: command parameters.
REQ-006 SHALL have port busy, output, 1 bit: high while a command is being executed (state != IDLE).
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when a command completes.
REQ-008 SHALL have port cmd_drop, output, 1 bit: sticky flag set when a strobe is ignored.
REQ-009 SHALL have port rd_row, input, 3 bits: framebuffer row select.
REQ-010 SHALL have port rd_data, output, 8 bits: combinational row read; bit i = pixel (x=i, y=rd_row).

Function
REQ-011 SHALL hold a 64-bit framebuffer, 8x8, as registers.
REQ-012 SHALL accept a command only when cmd_valid=1 and state=IDLE, latching all parameters on that edge.
REQ-013 SHALL ignore cmd_valid while busy, including the DONE cycle, and set cmd_drop; cmd_drop clears only on rst.
REQ-014 SHALL implement states IDLE, DRAW, DONE: IDLE->DRAW on accept; DRAW->DONE after the last write; DONE->IDLE unconditionally; done=1 only in DONE.
REQ-015 SHALL write at most one pixel per DRAW cycle, except CLEAR.
REQ-016 CLEAR SHALL zero one row per DRAW cycle, rows 0..7, for 8 DRAW cycles.
REQ-017 PIXEL SHALL write (x1,y1) in one DRAW cycle, so accept-to-done latency is 2 cycles.
REQ-018 LINE SHALL use integer Bresenham from (x1,y1) to (x2,y2), inclusive of both endpoints, with max(|dx|,|dy|)+1 DRAW cycles.
REQ-019 LINE SHALL use a signed error term of at least 5 bits and handle all octants, including dx=0, dy=0 and a single-point line.
REQ-020 RECT SHALL cover x1..min(x1+width-1,7) by y1..min(y1+height-1,7), scanned x-inner and y-outer, one pixel per cycle.
REQ-021 RECT extent arithmetic SHALL be 4 bits wide; off-grid pixels are clipped and not visited.
REQ-022 RECT with width=0 or height=0 SHALL go IDLE->DRAW->DONE with no write.
REQ-023 A framebuffer write SHALL be visible on rd_data in the cycle after its edge.

Reset
REQ-024 rst SHALL force state=IDLE, framebuffer=0, busy=0, done=0, cmd_drop=0, and all internal counters and latches to 0.
REQ-025 A command in flight when rst asserts SHALL be abandoned; partially drawn pixels are cleared by the framebuffer reset.

Configuration
REQ-026 With macro RASTER_XOR_EN defined, PIXEL, LINE and RECT SHALL toggle target pixels (XOR) instead of setting them to 1.
REQ-027 CLEAR SHALL behave identically with and without RASTER_XOR_EN.
REQ-028 Without RASTER_XOR_EN, writes SHALL set target pixels to 1.

Structure
REQ-029 A shared package raster_pkg SHALL hold: opcode constants (CLEAR/PIXEL/LINE/RECT), state encodings, GRID_DIM=8, COORD_W=3.
REQ-030 Bresenham stepping SHALL live in one sub-module, raster_line_stepper (load, step, x/y out, last flag); RECT and CLEAR counters stay in the top module.

Verification
REQ-031 The bench SHALL cover: reset, then PIXEL (3,5) -> busy for 2 cycles, done pulse, rd_row=5 gives 0x08.
REQ-032 The bench SHALL cover: LINE (0,0)->(7,7) -> 8 DRAW cycles; row r reads 1<<r for each r.
REQ-033 The bench SHALL cover: LINE (6,1)->(1,3), negative dx -> 6 cycles; pixels match a reference Bresenham model; also (2,2)->(2,2) gives 1 pixel.
REQ-034 The bench SHALL cover: RECT x1=6,y1=6,w=4,h=3 -> 4 DRAW cycles; rows 6 and 7 read 0xC0; width=0 gives no write and done 2 cycles after accept.
REQ-035 The bench SHALL cover: cmd_valid during busy and in the DONE cycle -> command ignored, cmd_drop=1 and stays 1; framebuffer unchanged by the dropped command.
REQ-036 The bench SHALL cover: CLEAR after a full rect -> all rows 0 after 8 DRAW cycles; rst mid-LINE -> all outputs 0 next cycle. Under RASTER_XOR_EN, PIXEL (3,5) issued twice leaves row 5 = 0x00.
